// File: rtl/mem_arbiter.sv
// Three-core round-robin arbiter onto a single one-cycle-latency synchronous memory port.
// Optional macro ARB_LOCK_EN: a winner holding lock during its response keeps the next grant.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    input  logic [2:0]            lock,
    output logic [2:0]            gnt,
    output logic [2:0]            ack,
    output logic [DATA_W-1:0]     rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] win_idx;
    logic [1:0] pick;
    logic       pick_ok;
    logic [2:0] scan_sum;
    logic [1:0] scan_idx;

`ifdef ARB_LOCK_EN
    logic       lock_valid;
    logic [1:0] lock_owner;
`else
    logic       unused_lock;
    assign unused_lock = ^lock;
`endif

    assign rdata = mem_rdata;

    // First requesting core scanning ptr, ptr+1, ptr+2 (mod 3); a held lock overrides the rotation.
    always_comb begin
        pick     = '0;
        pick_ok  = 1'b0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            scan_sum = {1'b0, ptr} + 3'(k);
            scan_idx = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
            if (!pick_ok && req[scan_idx]) begin
                pick    = scan_idx;
                pick_ok = 1'b1;
            end
        end
`ifdef ARB_LOCK_EN
        if (lock_valid && req[lock_owner]) begin
            pick = lock_owner;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            win_idx   <= '0;
            gnt       <= '0;
            ack       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef ARB_LOCK_EN
            lock_valid <= 1'b0;
            lock_owner <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        state     <= ISSUE;
                        win_idx   <= pick;
                        gnt       <= 3'b001 << pick;
                        mem_en    <= 1'b1;
                        mem_we    <= we[pick];
                        mem_addr  <= addr[pick*ADDR_W +: ADDR_W];
                        mem_wdata <= wdata[pick*DATA_W +: DATA_W];
                        busy      <= 1'b1;
`ifdef ARB_LOCK_EN
                        lock_valid <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    state  <= RESP;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    ack    <= gnt;
                end
                RESP: begin
                    state <= IDLE;
                    ack   <= '0;
                    gnt   <= '0;
                    busy  <= 1'b0;
`ifdef ARB_LOCK_EN
                    if (lock[win_idx]) begin
                        lock_valid <= 1'b1;
                        lock_owner <= win_idx;
                    end else begin
                        ptr <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
                    end
`else
                    ptr <= (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences, then random traffic vs a transaction model.
module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
`ifdef ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req, we, lock;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]    gnt, ack;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .lock(lock), .gnt(gnt), .ack(ack), .rdata(rdata), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory device attached to the DUT port.
    logic [DW-1:0] dev [256];
    initial begin
        for (int i = 0; i < 256; i++) dev[i] = '0;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dev[mem_addr] <= mem_wdata;
            else        mem_rdata     <= dev[mem_addr];
        end
    end

    // Transaction-level reference: a grant starts a 2-cycle access, then one idle arbitration cycle.
    logic [DW-1:0] refmem [256];
    int         cyc = 0;
    bit         m_act = 0;
    int         m_t0 = 0;
    int         m_core = 0;
    bit         m_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    int         m_ptr = 0;
    bit         m_lkv = 0;
    int         m_lko = 0;

    initial for (int i = 0; i < 256; i++) refmem[i] = '0;

    function automatic int pick_model(input logic [2:0] rq, input int p, input bit lkv, input int lko);
        if (lkv && rq[lko]) return lko;
        for (int k = 0; k < 3; k++) begin
            int c;
            c = (p + k) % 3;
            if (rq[c]) return c;
        end
        return 0;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (m_act && (cyc - m_t0) == 1 && m_we) refmem[m_addr] = m_wd;
        if (rst) begin
            m_act = 0; m_ptr = 0; m_lkv = 0;
        end else if (m_act) begin
            if ((cyc - m_t0) == 2) begin
                m_act = 0;
                if (LOCK_EN && lock[m_core]) begin
                    m_lkv = 1; m_lko = m_core;
                end else begin
                    m_ptr = (m_core + 1) % 3;
                end
            end
        end else if (req != 3'b000) begin
            m_core = pick_model(req, m_ptr, m_lkv, m_lko);
            m_lkv  = 0;
            m_act  = 1;
            m_t0   = cyc;
            m_we   = we[m_core];
            m_addr = addr[m_core*AW +: AW];
            m_wd   = wdata[m_core*DW +: DW];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_check();
        int a;
        logic [2:0] eg;
        a  = cyc - m_t0;
        eg = m_act ? 3'(1 << m_core) : 3'b000;
        chk("rnd_gnt",  gnt, eg);
        chk("rnd_ack",  ack, (m_act && a == 1) ? eg : 3'b000);
        chk("rnd_busy", busy, m_act);
        chk("rnd_en",   mem_en, (m_act && a == 0));
        chk("rnd_we",   mem_we, (m_act && a == 0 && m_we));
        if (m_act && a == 0) begin
            chk("rnd_addr", mem_addr, m_addr);
            if (m_we) chk("rnd_wdata", mem_wdata, m_wd);
        end
        if (m_act && a == 1 && !m_we) chk("rnd_rdata", rdata, refmem[m_addr]);
    endtask

    typedef struct {
        bit         rst;
        logic [2:0] req;
        logic [2:0] lock;
        logic [2:0] gnt;
        logic [2:0] ack;
        logic       busy;
        logic       en;
    } vec_t;

    localparam logic [2:0] G2 = LOCK_EN ? 3'b001 : 3'b010;
    localparam logic [2:0] G3 = LOCK_EN ? 3'b010 : 3'b001;

    vec_t tbl [19];
    int   ack_cnt, en_cnt;

    initial begin
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b000, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 3'b111, 3'b000, 3'b001, 3'b001, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'b111, 3'b000, 3'b010, 3'b000, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 3'b111, 3'b000, 3'b010, 3'b010, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'b111, 3'b000, 3'b100, 3'b000, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 3'b111, 3'b000, 3'b100, 3'b100, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 3'b111, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'b011, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 3'b011, 3'b001, 3'b001, 3'b001, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 3'b011, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 3'b011, 3'b001, G2,     3'b000, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 3'b011, 3'b001, G2,     G2,     1'b1, 1'b0};
        tbl[15] = '{1'b0, 3'b011, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 3'b011, 3'b000, G3,     3'b000, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 3'b011, 3'b000, G3,     G3,     1'b1, 1'b0};
        tbl[18] = '{1'b0, 3'b011, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};

        rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        tick();

        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; lock = tbl[i].lock; we = '0;
            tick();
            chk($sformatf("tbl%0d_gnt", i),  gnt,    tbl[i].gnt);
            chk($sformatf("tbl%0d_ack", i),  ack,    tbl[i].ack);
            chk($sformatf("tbl%0d_busy", i), busy,   tbl[i].busy);
            chk($sformatf("tbl%0d_en", i),   mem_en, tbl[i].en);
        end

        // Core 2 write then read back of the same address.
        rst = 1'b1; req = '0; lock = '0; tick();
        rst = 1'b0; req = 3'b010; we = 3'b010;
        addr = {8'h00, 8'h10, 8'h00}; wdata = {8'h00, 8'hA5, 8'h00};
        tick();
        chk("wr_en", mem_en, 1'b1);
        chk("wr_we", mem_we, 1'b1);
        chk("wr_addr", mem_addr, 8'h10);
        chk("wr_wdata", mem_wdata, 8'hA5);
        tick();
        chk("wr_ack", ack, 3'b010);
        req = '0; we = '0; tick();
        chk("wr_idle_busy", busy, 1'b0);
        req = 3'b010; tick();
        chk("rd_en", mem_en, 1'b1);
        chk("rd_we", mem_we, 1'b0);
        tick();
        chk("rd_ack", ack, 3'b010);
        chk("rd_rdata", rdata, 8'hA5);

        // Reset while a core-3 read is in ISSUE.
        req = '0; rst = 1'b1; tick();
        rst = 1'b0; req = 3'b100; addr = {8'h10, 8'h00, 8'h00}; tick();
        chk("rst_issue_gnt", gnt, 3'b100);
        rst = 1'b1; tick();
        chk("rst_gnt", gnt, 3'b000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, 3'b000);
        chk("rst_en", mem_en, 1'b0);
        rst = 1'b0; req = 3'b111; tick();
        chk("rst_regrant", gnt, 3'b001);
        tick();
        chk("rst_ack_next", ack, 3'b001);

        // Single continuous requester: one access per three cycles.
        req = '0; rst = 1'b1; tick();
        rst = 1'b0; req = 3'b001; ack_cnt = 0; en_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ack == 3'b001) ack_cnt++;
            if (mem_en) en_cnt++;
            if (ack[2:1] != 2'b00) chk("solo_other_ack", ack, 3'b000);
        end
        chk("solo_acks", ack_cnt, 4);
        chk("solo_en", en_cnt, 4);

        // Random traffic against the reference model.
        req = '0; rst = 1'b1; tick();
        for (int i = 0; i < 600; i++) begin
            rst  = ($urandom_range(0, 63) == 0);
            req  = 3'($urandom);
            we   = 3'($urandom);
            lock = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            for (int c = 0; c < 3; c++) begin
                addr[c*AW +: AW]  = AW'($urandom_range(0, 7));
                wdata[c*DW +: DW] = DW'($urandom);
            end
            tick();
            model_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, shared-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, shared-memory data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req  input  3  per-core access request, bit i = core i+1.
REQ-006 The block SHALL have port we  input  3  per-core write enable, qualified by req.
REQ-007 The block SHALL have port addr  input  3*ADDR_W  per-core address, core i in slice [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port wdata  input  3*DATA_W  per-core write data, same slicing.
REQ-009 The block SHALL have port lock  input  3  per-core keep-grant request, used only under ARB_LOCK_EN.
REQ-010 The block SHALL have port gnt  output  3  one-hot grant.
REQ-011 The block SHALL have port ack  output  3  one-cycle completion pulse per core.
REQ-012 The block SHALL have port rdata  output  DATA_W  read data, valid while ack is high for a read.
REQ-013 The block SHALL have ports mem_en/mem_we (output 1), mem_addr (output ADDR_W), mem_wdata (output DATA_W), mem_rdata (input DATA_W): one-cycle-latency synchronous memory port.
REQ-014 The block SHALL have port busy  output  1  high when state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, RESP; IDLE->ISSUE when req!=0, ISSUE->RESP always, RESP->IDLE always.
REQ-016 In IDLE with req!=0, the winner SHALL be the first set req bit scanning ptr, ptr+1, ptr+2 (mod 3); gnt is registered to the winner on entering ISSUE.
REQ-017 gnt SHALL stay constant through ISSUE and RESP and SHALL be 0 in IDLE.
REQ-018 In ISSUE, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the winner's we/addr/wdata slices; elsewhere mem_en=0 and mem_we=0.
REQ-019 In RESP, ack SHALL equal gnt for exactly one cycle; rdata SHALL equal mem_rdata combinationally.
REQ-020 Latency: req first seen in IDLE at cycle N gives mem_en at N+1 and ack at N+2; each access SHALL occupy exactly 3 cycles including the IDLE arbitration cycle.
REQ-021 On RESP, ptr SHALL become (winner+1) mod 3.
REQ-022 Requesters SHALL hold req/we/addr/wdata stable until ack; req still high in the IDLE cycle after ack is a new request.
REQ-023 Changes to req by a non-winner during ISSUE/RESP SHALL NOT affect the current transaction.
REQ-024 Dropping the winner's req during ISSUE/RESP SHALL NOT abort the transaction; ack still pulses.
REQ-025 Writes SHALL also produce ack; rdata is don't-care for writes.

Reset
REQ-026 rst high at a posedge SHALL force state=IDLE, ptr=0, gnt=0, ack=0, mem_en=0, mem_we=0, busy=0 in the following cycle, including mid-ISSUE or mid-RESP; the interrupted access gets no ack.
REQ-027 mem_addr and mem_wdata SHALL reset to 0.

Configuration
REQ-028 Macro ARB_LOCK_EN: when defined, if the RESP-cycle winner has lock=1, ptr SHALL stay unchanged and that core SHALL win the next IDLE arbitration if its req is 1, regardless of the rotation order.
REQ-029 Without ARB_LOCK_EN, lock SHALL be ignored and ptr SHALL always rotate per REQ-021.

Verification
REQ-030 After reset, req=3'b111 held for 9 cycles -> gnt sequence 001, 010, 100; acks at cycles 3, 6, 9.
REQ-031 Core 2 write addr=0x10 wdata=0xA5, then core 2 read addr=0x10 with mem model -> ack at N+2 each; rdata=0xA5 during the read ack.
REQ-032 req=3'b001 held continuously, no other requests -> core 1 acked every 3 cycles; mem_en duty 1/3.
REQ-033 rst asserted during ISSUE of a core-3 read -> no ack; gnt=0, busy=0 the next cycle; ptr=0, so a subsequent req=3'b111 grants core 1 first.
REQ-034 ARB_LOCK_EN defined, req=3'b011, lock=3'b001 -> core 1 granted on consecutive transactions; clear lock -> core 2 granted next.
REQ-035 ARB_LOCK_EN undefined, same stimulus as REQ-034 -> gnt alternates 001, 010.
